// File: rtl/matrix_vector_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : matrix_vector_mac_seq_if
// Brief   : Operand/result bundle for the column-serial matrix x vector MAC.
// Revision: 1.0
// ============================================================================
interface matrix_vector_mac_seq_if #(
   parameter int MATRIX_WIDTH  = 2,
   parameter int MATRIX_HEIGHT = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int ACC_WIDTH     = 2*DATA_WIDTH + $clog2(MATRIX_WIDTH)
);
   logic                                          i_calc;
   logic                                          i_signed;
   logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] i_matrix;
   logic [MATRIX_WIDTH*DATA_WIDTH-1:0]            i_vector;
   logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]            o_result;
   logic                                          o_ready;
   logic                                          o_busy;

   modport master (
      output i_calc, i_signed, i_matrix, i_vector,
      input  o_result, o_ready, o_busy
   );

   modport slave (
      input  i_calc, i_signed, i_matrix, i_vector,
      output o_result, o_ready, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/matrix_vector_mac_seq.sv
`default_nettype none
// ============================================================================
// Module  : matrix_vector_mac_seq
// Brief   : Column-serial matrix x vector multiplier, one column per clock.
// Revision: 1.0
// ============================================================================
module matrix_vector_mac_seq #(
   parameter int MATRIX_WIDTH  = 2,
   parameter int MATRIX_HEIGHT = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int ACC_WIDTH     = 2*DATA_WIDTH + $clog2(MATRIX_WIDTH)
) (
   input  wire logic               clk,
   input  wire logic               i_rst,
   matrix_vector_mac_seq_if.slave  bus
);
   localparam int c_col_w = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
   localparam logic [c_col_w-1:0] c_last_col = c_col_w'(MATRIX_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                                           state_q, state_d;
   logic [c_col_w-1:0]                               col_q, col_d;
   logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] mat_q, mat_d;
   logic [MATRIX_WIDTH*DATA_WIDTH-1:0]               vec_q, vec_d;
   logic                                             sgn_q, sgn_d;
   logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]               acc_q, acc_d;
   logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]               result_q, result_d;
   logic                                             ready_q, ready_d;
   logic                                             busy_q, busy_d;

   logic [DATA_WIDTH-1:0] w_vec_el;
   logic [ACC_WIDTH-1:0]  w_vec_ext;
   logic [ACC_WIDTH-1:0]  w_prod [MATRIX_HEIGHT];

   assign w_vec_el  = vec_q[int'(col_q)*DATA_WIDTH +: DATA_WIDTH];
   // Extending before the multiply keeps the truncated product exact modulo 2^ACC_WIDTH.
   assign w_vec_ext = sgn_q ? ACC_WIDTH'($signed(w_vec_el)) : ACC_WIDTH'(w_vec_el);

   generate
      for (genvar r = 0; r < MATRIX_HEIGHT; r++) begin : g_row
         logic [DATA_WIDTH-1:0] w_mat_el;
         logic [ACC_WIDTH-1:0]  w_mat_ext;
         assign w_mat_el  = mat_q[(r*MATRIX_WIDTH + int'(col_q))*DATA_WIDTH +: DATA_WIDTH];
         assign w_mat_ext = sgn_q ? ACC_WIDTH'($signed(w_mat_el)) : ACC_WIDTH'(w_mat_el);
         assign w_prod[r] = w_mat_ext * w_vec_ext;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      mat_d    = mat_q;
      vec_d    = vec_q;
      sgn_d    = sgn_q;
      acc_d    = acc_q;
      result_d = result_q;
      ready_d  = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.i_calc) begin
               mat_d   = bus.i_matrix;
               vec_d   = bus.i_vector;
               sgn_d   = bus.i_signed;
               acc_d   = '0;
               col_d   = '0;
               busy_d  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
               acc_d[r*ACC_WIDTH +: ACC_WIDTH] = acc_q[r*ACC_WIDTH +: ACC_WIDTH] + w_prod[r];
            end
            if (col_q == c_last_col) begin
               state_d = DONE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         DONE: begin
            result_d = acc_q;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         col_q    <= '0;
         mat_q    <= '0;
         vec_q    <= '0;
         sgn_q    <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         mat_q    <= mat_d;
         vec_q    <= vec_d;
         sgn_q    <= sgn_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.o_result = result_q;
   assign bus.o_ready  = ready_q;
   assign bus.o_busy   = busy_q;
endmodule
`default_nettype wire

// File: doc/matrix_vector_mac_seq.md
Name: matrix_vector_mac_seq

Overview:
Parametrised, column-serial matrix × vector multiplier. It is the successor to matrix_mult_vector and generalises it in four ways: arbitrary matrix dimensions, a separate accumulator width, a runtime signed/unsigned mode, and a busy/ready handshake with operand capture. One column is processed per clock, with all rows accumulated in parallel. It sits between the operand register file and the downstream result consumer.

Parameters:
MATRIX_WIDTH, 2, number of columns; this is also the vector length.
MATRIX_HEIGHT, 2, number of rows; this is also the result length.
DATA_WIDTH, 8, width of each matrix and vector element.
ACC_WIDTH, 2*DATA_WIDTH+$clog2(MATRIX_WIDTH), width of each accumulator and result element.

Ports:
clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_calc  input  1  start request; sampled only in IDLE.
i_signed  input  1  operand mode: 1 = two's complement, 0 = unsigned; captured with the operands.
i_matrix  input  MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH  element (r,c) at [(r*MATRIX_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH].
i_vector  input  MATRIX_WIDTH*DATA_WIDTH  element c at [c*DATA_WIDTH +: DATA_WIDTH].
o_result  output  MATRIX_HEIGHT*ACC_WIDTH  element r at [r*ACC_WIDTH +: ACC_WIDTH].
o_ready  output  1  one-cycle pulse when o_result has been updated.
o_busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (i_rst=1, asynchronous): state=IDLE; o_result=0, o_ready=0, o_busy=0; column counter, captured operands, mode and accumulators all cleared.
- Reset asserted mid-operation aborts the operation. No o_ready pulse is produced, and o_result returns to 0.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - o_busy=0.
  - When i_calc=1 at edge N: capture i_matrix, i_vector and i_signed into internal registers; clear all accumulators; col=0; go to MAC.
  - o_busy=1 from edge N.
- MAC:
  - Each edge, for every row r: acc[r] <= acc[r] + ext(m[r][col]) * ext(v[col]).
  - ext() is sign-extension to ACC_WIDTH when the captured mode is signed, zero-extension otherwise.
  - After the edge that processes col = MATRIX_WIDTH-1 (edge N+MATRIX_WIDTH): go to DONE. Otherwise col increments.
- DONE:
  - At edge N+MATRIX_WIDTH+1: o_result <= acc; o_ready <= 1 for exactly one cycle; o_busy <= 0; go to IDLE.
- Latency: o_ready is high in the cycle following edge N+MATRIX_WIDTH+1.
- Back-to-back operation: i_calc may be held high continuously. A new operation is captured on the same edge at which o_ready is deasserted, giving throughput of one result per MATRIX_WIDTH+2 cycles.
- i_calc while busy: ignored; no queueing, no error.
- Operand stability: i_matrix, i_vector and i_signed may change freely after capture. In-flight results use only the captured values.
- o_result holding: o_result holds its value between operations and changes only in DONE or on reset.
- Arithmetic: accumulation wraps modulo 2^ACC_WIDTH with no saturation. The default ACC_WIDTH guarantees no overflow for both modes. A smaller ACC_WIDTH is legal; results then wrap silently.
- MATRIX_WIDTH=1: exactly one MAC cycle; latency = 2 edges after capture.

Test Plan:
1. Basic unsigned case: W=H=2, m=[[2,3],[6,14]], v=[10,14], i_signed=0, i_calc pulsed -> o_busy high 3 cycles; o_ready is a single pulse after edge N+3; result r0=62 (0x3E), r1=256 (0x100).
2. Same matrix, v=[0xFF,14]:
   - i_signed=0 -> r0=552, r1=1726.
   - i_signed=1 -> r0=40, r1=190.
3. Width extremes:
   - All elements 0xFF, unsigned -> each result = 130050 (0x1FC02).
   - All elements 0x80, signed -> each result = 32768 (0x08000).
4. i_calc held high for 3 operations, with operands changed on the cycle after each capture -> o_ready pulses exactly every 4 cycles; each result matches the operands present at its capture edge.
5. i_rst asserted asynchronously (not edge-aligned) during the MAC state -> o_busy, o_ready and o_result go to 0 immediately; no o_ready pulse follows; the next i_calc after reset release produces a correct result.
6. Parameter sweep: W=3, H=4, DATA_WIDTH=4 with random operands, 200 operations -> every result matches a reference model (modulo 2^ACC_WIDTH); latency is always 4 edges after capture.
